// File: rtl/wb_regfile_if.sv
// MEM/WB writeback bus plus the register-file read, forwarding and debug ports.
// The master is the pipeline side; the slave is wb_regfile.
interface wb_regfile_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic              regW_in;
   logic              memToR_in;
   logic [ADDR_W-1:0] gprDes_in;
   logic [DATA_W-1:0] aluOut_in;
   logic [DATA_W-1:0] memOut_in;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic [DATA_W-1:0] wbData_out;
   logic [ADDR_W-1:0] wbLastDes_out;
   logic [DATA_W-1:0] wbLastData_out;
   logic              wbLastValid_out;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;

   modport master (
      output regW_in, memToR_in, gprDes_in, aluOut_in, memOut_in,
             rs_addr, rt_addr, dbg_addr,
      input  rs_data, rt_data, wbData_out, wbLastDes_out, wbLastData_out,
             wbLastValid_out, dbg_data
   );

   modport slave (
      input  regW_in, memToR_in, gprDes_in, aluOut_in, memOut_in,
             rs_addr, rt_addr, dbg_addr,
      output rs_data, rt_data, wbData_out, wbLastDes_out, wbLastData_out,
             wbLastValid_out, dbg_data
   );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and GPR file: selects the MEM/WB result, commits it, serves
// two read ports with optional write-through bypass, and records the last write.
module wb_regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter bit          BYPASS = 1'b1
) (
   input logic         clk,
   input logic         rst,
   wb_regfile_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] gpr [DEPTH];
   logic [DATA_W-1:0] wbData;
   logic              we;
   logic [ADDR_W-1:0] lastDes;
   logic [DATA_W-1:0] lastData;
   logic              lastValid;

   // r0 is excluded from the enable so it also never bypasses.
   always_comb begin
      wbData = bus.memToR_in ? bus.memOut_in : bus.aluOut_in;
      we     = bus.regW_in && (bus.gprDes_in != '0) && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) gpr[i] <= '0;
         lastDes   <= '0;
         lastData  <= '0;
         lastValid <= 1'b0;
      end else begin
         if (we) gpr[bus.gprDes_in] <= wbData;
         lastDes   <= bus.gprDes_in;
         lastData  <= wbData;
         lastValid <= we;
      end
   end

   always_comb begin
      bus.rs_data = gpr[bus.rs_addr];
      if (bus.rs_addr == '0)
         bus.rs_data = '0;
      else if (BYPASS && we && (bus.rs_addr == bus.gprDes_in))
         bus.rs_data = wbData;
   end

   always_comb begin
      bus.rt_data = gpr[bus.rt_addr];
      if (bus.rt_addr == '0)
         bus.rt_data = '0;
      else if (BYPASS && we && (bus.rt_addr == bus.gprDes_in))
         bus.rt_data = wbData;
   end

   always_comb begin
      bus.wbData_out      = wbData;
      bus.dbg_data        = gpr[bus.dbg_addr];
      bus.wbLastDes_out   = lastDes;
      bus.wbLastData_out  = lastData;
      bus.wbLastValid_out = lastValid;
   end
endmodule
